// File: rtl/multicycle_datapath.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : multicycle_datapath
// Purpose  : Multi-cycle datapath sequencing FETCH/DECODE/EXEC/MEM/WB with a
//            unified req/ack memory port and an external combinational
//            control unit decoding the instruction register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module multicycle_datapath #(
   parameter int              XLEN     = 32,
   parameter int              AW       = 12,
   parameter logic [AW-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [31:0]       instr,
   input  logic              regRW,
   input  logic              ALUsrc,
   input  logic [1:0]        immsrc,
   input  logic [3:0]        ALUop,
   input  logic              mRW,
   input  logic              wb,
   input  logic              pcsrc,
   input  logic              memop,
   output logic [3:0]        status,
   output logic [2:0]        phase,
   output logic              retire,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_ack
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SLTU  = 4'd9;
   localparam logic [3:0] OP_PASSB = 4'd10;

   logic [2:0]      state;
   logic [2:0]      state_next;
   logic [AW-1:0]   pc;
   logic [31:0]     ir;
   logic [XLEN-1:0] rf [0:31];
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] alu_out;
   logic [XLEN-1:0] mdr;

   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] opb;
   logic [4:0]      shamt;
   logic [XLEN:0]   sum_add;
   logic [XLEN:0]   sum_sub;
   logic [XLEN-1:0] alu_res;
   logic            alu_c;
   logic            alu_v;

   assign instr = ir;
   assign phase = state;

   // Immediate extraction from IR according to the decoded format
   always_comb begin
      imm32 = '0;
      case (immsrc)
         2'b00:   imm32 = {{20{ir[31]}}, ir[31:20]};
         2'b01:   imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         2'b10:   imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         default: imm32 = {ir[31:12], 12'b0};
      endcase
      imm_ext = XLEN'($signed(imm32));
   end

   // ALU: result plus carry/overflow; C is not-borrow for subtraction
   always_comb begin
      opb     = ALUsrc ? b : imm;
      shamt   = opb[4:0];
      sum_add = {1'b0, a} + {1'b0, opb};
      sum_sub = {1'b0, a} + {1'b0, ~opb} + (XLEN+1)'(1);
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (ALUop)
         OP_ADD: begin
            alu_res = sum_add[XLEN-1:0];
            alu_c   = sum_add[XLEN];
            alu_v   = (a[XLEN-1] == opb[XLEN-1]) && (sum_add[XLEN-1] != a[XLEN-1]);
         end
         OP_SUB: begin
            alu_res = sum_sub[XLEN-1:0];
            alu_c   = sum_sub[XLEN];
            alu_v   = (a[XLEN-1] != opb[XLEN-1]) && (sum_sub[XLEN-1] != a[XLEN-1]);
         end
         OP_AND:   alu_res = a & opb;
         OP_OR:    alu_res = a | opb;
         OP_XOR:   alu_res = a ^ opb;
         OP_SLL:   alu_res = a << shamt;
         OP_SRL:   alu_res = a >> shamt;
         OP_SRA:   alu_res = $unsigned($signed(a) >>> shamt);
         OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(opb))};
         OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (a < opb)};
         OP_PASSB: alu_res = opb;
         default:  alu_res = '0;
      endcase
   end

   // Phase register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Phase sequencing; memory phases stall until acknowledged
   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:  state_next = mem_ack ? S_DECODE : S_FETCH;
         S_DECODE: state_next = S_EXEC;
         S_EXEC:   state_next = memop ? S_MEM : S_WB;
         S_MEM:    state_next = mem_ack ? S_WB : S_MEM;
         S_WB:     state_next = S_FETCH;
         default:  state_next = S_FETCH;
      endcase
   end

   // Memory port and retire strobe; request is gated by reset so it drops at once
   always_comb begin
      mem_req   = rst && ((state == S_FETCH) || (state == S_MEM));
      mem_we    = rst && (state == S_MEM) && !mRW;
      mem_addr  = (state == S_MEM) ? alu_out[AW-1:0] : pc;
      mem_wdata = (state == S_MEM) ? b : '0;
      retire    = (state == S_WB);
   end

   // Architectural and intermediate registers, each loaded in its own phase
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc      <= RESET_PC;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         imm     <= '0;
         alu_out <= '0;
         mdr     <= '0;
         status  <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ack) begin
                  ir <= mem_rdata[31:0];
               end
            end
            S_DECODE: begin
               a   <= (ir[19:15] == 5'd0) ? '0 : rf[ir[19:15]];
               b   <= (ir[24:20] == 5'd0) ? '0 : rf[ir[24:20]];
               imm <= imm_ext;
            end
            S_EXEC: begin
               alu_out <= alu_res;
               status  <= {alu_res[XLEN-1], (alu_res == '0), alu_c, alu_v};
            end
            S_MEM: begin
               if (mem_ack && mRW) begin
                  mdr <= mem_rdata;
               end
            end
            S_WB: begin
               pc <= pcsrc ? (pc + AW'(4)) : (pc + imm[AW-1:0]);
            end
            default: begin
            end
         endcase
      end
   end

   // Register file write in WB; x0 is never written
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            rf[i] <= '0;
         end
      end else if ((state == S_WB) && regRW && (ir[11:7] != 5'd0)) begin
         rf[ir[11:7]] <= wb ? mdr : alu_out;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_multicycle_datapath
// Purpose  : Randomised self-checking bench for multicycle_datapath with an
//            ISA-level reference model, memory responder and retire monitor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_multicycle_datapath;

   localparam int XLEN = 32;
   localparam int AW   = 12;

   logic            clk = 1'b0;
   logic            rst;
   logic [31:0]     instr;
   logic            regRW, ALUsrc, mRW, wb, pcsrc, memop;
   logic [1:0]      immsrc;
   logic [3:0]      ALUop;
   logic [3:0]      status;
   logic [2:0]      phase;
   logic            retire;
   logic            mem_req, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_ack;

   multicycle_datapath #(.XLEN(XLEN), .AW(AW), .RESET_PC(12'h000)) dut (
      .clk(clk), .rst(rst), .instr(instr),
      .regRW(regRW), .ALUsrc(ALUsrc), .immsrc(immsrc), .ALUop(ALUop),
      .mRW(mRW), .wb(wb), .pcsrc(pcsrc), .memop(memop),
      .status(status), .phase(phase), .retire(retire),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] fetch_addr;
      logic [3:0]  status;
      bit          is_mem;
      bit          is_store;
      logic [11:0] st_addr;
      logic [31:0] st_data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] directed[$];
   logic [31:0] xr [0:31];
   logic [11:0] mpc;
   logic [31:0] mem [0:4095];

   int checks = 0;
   int errors = 0;
   int n_retired = 0;
   int inst_waits = 0;
   bit rst_toggle = 0;
   bit force_mem_wait = 0;

   // Control unit: combinational decode of the instruction register
   always_comb begin
      regRW = 1'b0; ALUsrc = 1'b0; immsrc = 2'b00; ALUop = 4'd0;
      mRW = 1'b1; wb = 1'b0; pcsrc = 1'b1; memop = 1'b0;
      case (instr[6:0])
         7'b0010011: regRW = 1'b1;
         7'b0110011: begin
            regRW = 1'b1; ALUsrc = 1'b1;
            case (instr[14:12])
               3'd0: ALUop = instr[30] ? 4'd1 : 4'd0;
               3'd1: ALUop = 4'd5;
               3'd2: ALUop = 4'd8;
               3'd3: ALUop = 4'd9;
               3'd4: ALUop = 4'd4;
               3'd5: ALUop = instr[30] ? 4'd7 : 4'd6;
               3'd6: ALUop = 4'd3;
               default: ALUop = 4'd2;
            endcase
         end
         7'b0110111: begin regRW = 1'b1; immsrc = 2'b11; ALUop = 4'd10; end
         7'b0100011: begin immsrc = 2'b01; memop = 1'b1; mRW = 1'b0; end
         7'b0000011: begin regRW = 1'b1; memop = 1'b1; mRW = 1'b1; wb = 1'b1; end
         7'b1100011: begin immsrc = 2'b10; ALUop = 4'd1; ALUsrc = 1'b1; pcsrc = 1'b0; end
         default: ;
      endcase
   end

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
      return {imm, rd, 7'b0110111};
   endfunction

   // Flags from plain integer arithmetic: kind 0 add, 1 sub, 2 logical/other
   function automatic logic [3:0] flags(input int kind, input logic [31:0] a,
                                        input logic [31:0] bv, input logic [31:0] r);
      longint sa, sbv, s;
      bit c, v;
      sa = longint'($signed(a));
      sbv = longint'($signed(bv));
      c = 1'b0; v = 1'b0;
      if (kind == 0) begin
         c = (longint'(a) + longint'(bv)) > 64'sd4294967295;
         s = sa + sbv;
         v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end else if (kind == 1) begin
         c = (a >= bv);
         s = sa - sbv;
         v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      return {r[31], (r == 32'd0), c, v};
   endfunction

   function automatic logic [31:0] rand_instr();
      int k;
      logic [4:0] rd, rs1, rs2;
      logic [2:0] f3;
      logic [6:0] f7;
      k   = $urandom_range(0, 99);
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      if (k < 25) return enc_i(12'($urandom), rs1, 3'b000, rd, 7'b0010011);
      if (k < 50) begin
         f3 = 3'($urandom_range(0, 7));
         f7 = (((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) == 1)) ? 7'h20 : 7'h00;
         return enc_r(f7, rs2, rs1, f3, rd);
      end
      if (k < 60) return enc_u(20'($urandom), rd);
      if (k < 75) return enc_s(12'($urandom), rs2, rs1);
      if (k < 88) return enc_i(12'($urandom), rs1, 3'b010, rd, 7'b0000011);
      return enc_b({12'($urandom), 1'b0}, rs2, rs1);
   endfunction

   // ISA-level model: executes one instruction and queues what the DUT must show
   task automatic model_issue(input logic [31:0] ins);
      exp_t e;
      logic [31:0] a, bv, r, immi, imms, immb, addr;
      logic [4:0]  rd;
      logic [11:0] npc;
      bit wr;
      rd   = ins[11:7];
      a    = xr[ins[19:15]];
      bv   = xr[ins[24:20]];
      immi = {{20{ins[31]}}, ins[31:20]};
      imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      e.fetch_addr = mpc; e.status = 4'd0; e.is_mem = 0; e.is_store = 0;
      e.st_addr = 12'd0; e.st_data = 32'd0;
      npc = mpc + 12'd4; wr = 0; r = 32'd0;
      case (ins[6:0])
         7'b0010011: begin r = a + immi; e.status = flags(0, a, immi, r); wr = 1; end
         7'b0110011: begin
            wr = 1;
            case (ins[14:12])
               3'd0: r = ins[30] ? (a - bv) : (a + bv);
               3'd1: r = a << bv[4:0];
               3'd2: r = ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0;
               3'd3: r = (a < bv) ? 32'd1 : 32'd0;
               3'd4: r = a ^ bv;
               3'd5: r = ins[30] ? $unsigned($signed(a) >>> bv[4:0]) : (a >> bv[4:0]);
               3'd6: r = a | bv;
               default: r = a & bv;
            endcase
            if (ins[14:12] == 3'd0) e.status = flags(ins[30] ? 1 : 0, a, bv, r);
            else e.status = flags(2, a, bv, r);
         end
         7'b0110111: begin r = {ins[31:12], 12'd0}; e.status = flags(2, a, r, r); wr = 1; end
         7'b0100011: begin
            addr = a + imms; e.status = flags(0, a, imms, addr);
            e.is_mem = 1; e.is_store = 1; e.st_addr = addr[11:0]; e.st_data = bv;
         end
         7'b0000011: begin
            addr = a + immi; e.status = flags(0, a, immi, addr);
            e.is_mem = 1; r = mem[addr[11:0]]; wr = 1;
         end
         default: begin
            r = a - bv; e.status = flags(1, a, bv, r);
            npc = mpc + immb[11:0];
         end
      endcase
      if (wr && (rd != 5'd0)) xr[rd] = r;
      mpc = npc;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory responder with random wait states and spurious idle acks
   initial begin : driver
      logic [31:0] ins;
      bit busy;
      bit tog;
      int wait_left;
      busy = 0; tog = 0; wait_left = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (!rst) begin
            busy = 0;
            tog = ~tog;
            mem_ack = rst_toggle ? tog : 1'b0;
         end else if (mem_req) begin
            if (!busy) begin
               busy = 1;
               if (phase == 3'd0) inst_waits = 0;
               if (force_mem_wait && (phase == 3'd3)) wait_left = 8;
               else wait_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            if (wait_left == 0) begin
               mem_ack = 1'b1;
               busy = 0;
               if (phase == 3'd0) begin
                  if (directed.size() > 0) ins = directed.pop_front();
                  else ins = rand_instr();
                  model_issue(ins);
                  mem_rdata = ins;
               end else if (mem_we) begin
                  mem[mem_addr] = mem_wdata;
                  mem_rdata = $urandom;
               end else begin
                  mem_rdata = mem[mem_addr];
               end
            end else begin
               wait_left--;
               inst_waits++;
               mem_rdata = $urandom;
            end
         end else begin
            busy = 0;
            mem_ack = ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
         end
      end
   end

   // Monitor: handshake stability and per-retire scoreboard comparison
   initial begin : monitor
      exp_t e;
      int cyc, fetch_start, st_seen;
      bit in_fetch, have_prev, prev_req, prev_ack, p_we;
      logic [11:0] act_fetch, st_addr, p_addr;
      logic [31:0] st_data, p_wdata;
      cyc = 0; fetch_start = 0; st_seen = 0; in_fetch = 0; have_prev = 0;
      prev_req = 0; prev_ack = 0; p_we = 0; act_fetch = '0; st_addr = '0;
      p_addr = '0; st_data = '0; p_wdata = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            in_fetch = 0; st_seen = 0; have_prev = 0;
         end else begin
            if (have_prev && prev_req && !prev_ack && mem_req) begin
               chk("hold_addr", mem_addr, p_addr);
               chk("hold_we", mem_we, p_we);
               chk("hold_wdata", mem_wdata, p_wdata);
            end
            have_prev = 1; prev_req = mem_req; prev_ack = mem_ack;
            p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
            if ((phase == 3'd0) && mem_req && !in_fetch) begin
               in_fetch = 1; fetch_start = cyc;
            end
            if (mem_req && mem_ack && (phase == 3'd0)) act_fetch = mem_addr;
            if (mem_req && mem_ack && mem_we) begin
               st_seen++; st_addr = mem_addr; st_data = mem_wdata;
            end
            if (retire) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL retire_unexpected: got retire with empty scoreboard, expected none");
               end else begin
                  e = sb.pop_front();
                  chk("fetch_addr", act_fetch, e.fetch_addr);
                  chk("status", status, e.status);
                  chk("latency", cyc - fetch_start + 1, 4 + int'(e.is_mem) + inst_waits);
                  chk("store_count", st_seen, e.is_store ? 1 : 0);
                  if (e.is_store) begin
                     chk("store_addr", st_addr, e.st_addr);
                     chk("store_data", st_data, e.st_data);
                  end
               end
               st_seen = 0; in_fetch = 0; n_retired++;
            end
         end
      end
   end

   // Main sequence: reset checks, directed prologue, random run, mid-MEM reset
   initial begin : main
      bit found;
      rst = 1'b0;
      rst_toggle = 1;
      for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
      for (int i = 0; i < 32; i++) xr[i] = 32'd0;
      mpc = 12'd0;
      directed.push_back(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
      directed.push_back(enc_s(12'd8, 5'd1, 5'd0));
      directed.push_back(enc_i(12'd8, 5'd0, 3'b010, 5'd2, 7'b0000011));
      directed.push_back(enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011));
      directed.push_back(enc_b(13'h1FF8, 5'd0, 5'd0));
      directed.push_back(enc_s(12'd12, 5'd2, 5'd0));
      directed.push_back(enc_s(12'd16, 5'd0, 5'd0));
      directed.push_back(enc_b(13'h1FF0, 5'd0, 5'd0));
      directed.push_back(enc_b(13'h1FF8, 5'd0, 5'd0));

      repeat (5) begin
         @(negedge clk);
         chk("rst_mem_req", mem_req, 0);
         chk("rst_phase", phase, 0);
         chk("rst_status", status, 0);
         chk("rst_retire", retire, 0);
      end
      chk("rst_instr", instr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      rst_toggle = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rel_mem_req", mem_req, 1);
      chk("rel_mem_addr", mem_addr, 0);
      chk("rel_mem_we", mem_we, 0);

      for (int i = 0; (i < 20000) && (n_retired < 150); i++) @(negedge clk);
      if (n_retired < 150) begin
         checks++; errors++;
         $display("FAIL timeout_run1: got %0d retires expected 150", n_retired);
      end

      force_mem_wait = 1;
      found = 0;
      for (int i = 0; (i < 2000) && !found; i++) begin
         @(negedge clk);
         if ((phase == 3'd3) && mem_req && !mem_ack) found = 1;
      end
      if (!found) begin
         checks++; errors++;
         $display("FAIL timeout_mem_wait: got no MEM wait expected one");
      end else begin
         #1 rst = 1'b0;
         #1;
         chk("midrst_mem_req", mem_req, 0);
         chk("midrst_phase", phase, 0);
         chk("midrst_mem_addr", mem_addr, 0);
         chk("midrst_retire", retire, 0);
         chk("midrst_status", status, 0);
         sb.delete();
         for (int i = 0; i < 32; i++) xr[i] = 32'd0;
         mpc = 12'd0;
         force_mem_wait = 0;
         repeat (2) @(negedge clk);
         rst = 1'b1;
      end
      force_mem_wait = 0;

      for (int i = 0; (i < 20000) && (n_retired < 260); i++) @(negedge clk);
      if (n_retired < 260) begin
         checks++; errors++;
         $display("FAIL timeout_run2: got %0d retires expected 260", n_retired);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
